gate_truth_table_checker: RTL and testbench

//  Drives the two inputs of a 2-input gate under test through all four input

---
 rtl/gate_truth_table_checker_pkg.sv | 20 ++
 rtl/gate_truth_table_checker_sync_2ff.sv | 29 ++
 rtl/gate_truth_table_checker.sv | 134 +++++++++++++
 tb/tb_gate_truth_table_checker.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/gate_truth_table_checker_pkg.sv
// rtl/gate_truth_table_checker_pkg.sv - shared state encoding and gate truth tables
package gate_truth_table_checker_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SAMPLE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Indexed by {A,B}: bit0 is A=0,B=0.
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_table_checker_sync_2ff.sv
// rtl/gate_truth_table_checker_sync_2ff.sv - 1-bit two-flop synchroniser, sync active-high reset
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gate_truth_table_checker.sv
// rtl/gate_truth_table_checker.sv - steps a 2-input gate through all vectors and checks its output
module gate_truth_table_checker
   import gate_truth_table_checker_pkg::*;
#(
   parameter logic [3:0] EXPECTED      = TT_NAND,
   parameter int         SETTLE_CYCLES = 16,
   parameter int         HOLD_CYCLES   = 100_000_000,
   parameter int         CNT_W         = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       gate_a,
   output logic       gate_b,
   input  logic       gate_y,
   output logic [1:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

   logic             y_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       vec_idx_q, vec_idx_d;
   logic             gate_a_q, gate_a_d;
   logic             gate_b_q, gate_b_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [3:0]       fail_mask_q, fail_mask_d;

   sync_2ff u_sync_y (
      .clk (clk),
      .rst (rst),
      .d   (gate_y),
      .q   (y_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      vec_idx_d   = vec_idx_q;
      gate_a_d    = gate_a_q;
      gate_b_d    = gate_b_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_mask_d = fail_mask_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = DRIVE;
               cnt_d       = '0;
               vec_idx_d   = 2'd0;
               gate_a_d    = 1'b0;
               gate_b_d    = 1'b0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               fail_mask_d = 4'b0000;
            end
         end
         DRIVE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            fail_mask_d[vec_idx_q] = (y_s != EXPECTED[vec_idx_q]);
            state_d                = HOLD;
            cnt_d                  = '0;
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d = '0;
               if (vec_idx_q == 2'd3) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = ~|fail_mask_q;
               end else begin
                  // Gate drive moves on the same edge as the index so they never disagree.
                  state_d   = DRIVE;
                  vec_idx_d = vec_idx_q + 2'd1;
                  gate_a_d  = vec_idx_d[1];
                  gate_b_d  = vec_idx_d[0];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         vec_idx_q   <= 2'd0;
         gate_a_q    <= 1'b0;
         gate_b_q    <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= 4'b0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vec_idx_q   <= vec_idx_d;
         gate_a_q    <= gate_a_d;
         gate_b_q    <= gate_b_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_mask_q <= fail_mask_d;
      end
   end

   assign gate_a    = gate_a_q;
   assign gate_b    = gate_b_q;
   assign vec_idx   = vec_idx_q;
   assign busy      = (state_q == DRIVE) || (state_q == SAMPLE) || (state_q == HOLD);
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb/tb_gate_truth_table_checker.sv - table-driven bench for gate_truth_table_checker
module tb_gate_truth_table_checker;
   import gate_truth_table_checker_pkg::*;

   localparam int S   = 4;
   localparam int H   = 2;
   localparam int VEC = S + 1 + H;
   localparam int LAT = 4 * VEC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       gate_a, gate_b, gate_y;
   logic [1:0] vec_idx;
   logic       busy, done, pass;
   logic [3:0] fail_mask;

   int  mode = 0;
   bit  glitch = 1'b0;
   int  checks = 0;
   int  errors = 0;

   gate_truth_table_checker #(
      .EXPECTED      (TT_NAND),
      .SETTLE_CYCLES (S),
      .HOLD_CYCLES   (H),
      .CNT_W         (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .gate_a    (gate_a),
      .gate_b    (gate_b),
      .gate_y    (gate_y),
      .vec_idx   (vec_idx),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_mask (fail_mask)
   );

   always #5 clk = ~clk;

   // Gate models: 0 NAND, 1 AND, 2 NAND stuck-at-1 on vector 3, 3 XOR, 4 OR
   function automatic logic gate_model(input int m, input logic a, input logic b);
      case (m)
         1:       return a & b;
         2:       return 1'b1;
         3:       return a ^ b;
         4:       return a | b;
         default: return ~(a & b);
      endcase
   endfunction

   assign gate_y = glitch ? 1'b0 : gate_model(mode, gate_a, gate_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   typedef struct {
      string      name;
      int         mode;
      logic [3:0] mask;
      logic       pass_e;
      int         extra_start;
      bit         glitch_v0;
   } run_t;

   task automatic run_full(input run_t r);
      int         n;
      bit         seq_ok;
      logic [1:0] exp_vec;
      mode   = r.mode;
      do_start();
      n      = 0;
      seq_ok = 1'b1;
      check({r.name, " restart clears"}, {28'd0, done, pass, fail_mask[1:0]} | {28'd0, 2'b00, fail_mask[3:2]}, 32'd0);
      while (!done && n < 200) begin
         exp_vec = 2'(n / VEC);
         if (vec_idx !== exp_vec || gate_a !== exp_vec[1] || gate_b !== exp_vec[0] || busy !== 1'b1)
            seq_ok = 1'b0;
         if (r.glitch_v0) glitch = (n == 0);
         if (r.extra_start >= 0) start = (n == r.extra_start);
         @(negedge clk);
         n++;
      end
      glitch = 1'b0;
      start  = 1'b0;
      check({r.name, " latency"}, n, LAT);
      check({r.name, " vector sequence"}, {31'd0, seq_ok}, 32'd1);
      check({r.name, " fail_mask"}, {28'd0, fail_mask}, {28'd0, r.mask});
      check({r.name, " pass"}, {31'd0, pass}, {31'd0, r.pass_e});
      check({r.name, " idle after done"}, {29'd0, busy, vec_idx}, {29'd0, 1'b0, 2'd3});
   endtask

   run_t runs[6];

   initial begin
      runs[0] = '{"nand",        0, 4'b0000, 1'b1, -1, 1'b0};
      runs[1] = '{"and",         1, 4'b1111, 1'b0, -1, 1'b0};
      runs[2] = '{"stuck_v3",    2, 4'b1000, 1'b0, -1, 1'b0};
      runs[3] = '{"xor",         3, 4'b0001, 1'b0, -1, 1'b0};
      runs[4] = '{"or",          4, 4'b1001, 1'b0, -1, 1'b0};
      runs[5] = '{"busy_start",  0, 4'b0000, 1'b1, 10, 1'b0};

      repeat (3) @(negedge clk);
      check("reset outputs", {23'd0, gate_a, gate_b, vec_idx, busy, done, pass, fail_mask[1:0]},
            32'd0);
      check("reset fail_mask", {28'd0, fail_mask}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle holds", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 6; i++) run_full(runs[i]);

      // Glitch on gate_y during vector 0 settle must not register.
      run_full('{"glitch_v0", 0, 4'b0000, 1'b1, -1, 1'b1});

      // Reset mid-run discards the partial mask (AND already failed vector 0).
      mode = 1;
      do_start();
      repeat (11) @(negedge clk);
      check("mask before rst", {31'd0, fail_mask[0]}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst mid-run", {24'd0, gate_a, gate_b, vec_idx, busy, done, pass, 1'b0} | {28'd0, fail_mask},
            32'd0);
      start = 1'b1;
      @(negedge clk);
      check("rst beats start", {31'd0, busy}, 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      check("idle after rst", {31'd0, busy}, 32'd0);
      run_full('{"after_rst", 0, 4'b0000, 1'b1, -1, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
